// File: rtl/dac_write_arbiter.sv
// Shares one DAC serial write engine among N_REQ valid/ready sources, with fixed-priority or
// round-robin arbitration, a minimum start-to-start interval and a busy-rise timeout guard.
module dac_write_arbiter #(
    parameter int unsigned DAC_WIDTH    = 16,
    parameter int unsigned N_REQ        = 3,
    parameter int unsigned BUSY_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       sreset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DAC_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       rr_enable,
    input  logic [15:0]                min_interval,
    input  logic                       err_clear,
    output logic [DAC_WIDTH-1:0]       dac_data,
    output logic                       dac_start,
    input  logic                       dac_busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       timeout_err,
    output logic [31:0]                update_count
);

    localparam int unsigned IdW = $clog2(N_REQ);
    localparam int unsigned ToW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StStart    = 2'd1;
    localparam logic [1:0] StWaitBusy = 2'd2;
    localparam logic [1:0] StWaitDone = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]       grant_q, grant_d;
    logic [DAC_WIDTH-1:0] data_q, data_d;
    logic [15:0]          since_start_q, since_start_d;
    logic [ToW-1:0]       to_cnt_q, to_cnt_d;
    logic                 err_q, err_d;
    logic [31:0]          count_q, count_d;

    logic                 fp_hit, rr_hit, interval_met, accept;
    logic [IdW-1:0]       fp_idx, rr_idx, winner;

    function automatic logic [IdW-1:0] rr_index(input logic [IdW-1:0] ptr, input int unsigned k);
        int unsigned j;
        j = 32'(ptr) + k;
        if (j >= N_REQ) j = j - N_REQ;
        return IdW'(j);
    endfunction

    // Both searches iterate from the far end so the last hit is the winning one.
    always_comb begin
        fp_hit = 1'b0;
        fp_idx = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                fp_hit = 1'b1;
                fp_idx = IdW'(i);
            end
        end
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            if (req_valid[rr_index(rr_ptr_q, k)]) begin
                rr_hit = 1'b1;
                rr_idx = rr_index(rr_ptr_q, k);
            end
        end
    end

    // since_start reads 0 in the dac_start cycle, so starts land exactly min_interval apart.
    assign interval_met = ({1'b0, since_start_q} + 17'd1) >= {1'b0, min_interval};
    assign winner       = rr_enable ? rr_idx : fp_idx;
    assign accept       = (state_q == StIdle) && (fp_hit || rr_hit) && interval_met && !sreset;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            req_ready[i] = accept && (winner == IdW'(i));
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        data_d        = data_q;
        to_cnt_d      = to_cnt_q;
        err_d         = err_q;
        count_d       = count_q;
        since_start_d = (since_start_q == 16'hFFFF) ? since_start_q : since_start_q + 16'd1;
        if (err_clear) err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    rr_ptr_d      = winner;
                    grant_d       = winner;
                    data_d        = req_data[32'(winner) * DAC_WIDTH +: DAC_WIDTH];
                    since_start_d = '0;
                    state_d       = StStart;
                end
            end
            StStart: begin
                to_cnt_d = '0;
                state_d  = StWaitBusy;
            end
            StWaitBusy: begin
                if (dac_busy) begin
                    state_d = StWaitDone;
                end else if (to_cnt_q == ToW'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + ToW'(1);
                end
            end
            StWaitDone: begin
                if (!dac_busy) begin
                    count_d = count_q + 32'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q       <= StIdle;
            rr_ptr_q      <= IdW'(N_REQ - 1);
            grant_q       <= '0;
            data_q        <= '0;
            since_start_q <= 16'hFFFF;
            to_cnt_q      <= '0;
            err_q         <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            data_q        <= data_d;
            since_start_q <= since_start_d;
            to_cnt_q      <= to_cnt_d;
            err_q         <= err_d;
            count_q       <= count_d;
        end
    end

    assign dac_start    = (state_q == StStart);
    assign dac_data     = data_q;
    assign grant_id     = grant_q;
    assign timeout_err  = err_q;
    assign update_count = count_q;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Directed bench for dac_write_arbiter: inputs change on the falling edge, outputs are
// observed on the falling edge (registered) or 1 ns after an input change (combinational).
module tb_dac_write_arbiter;

    logic        clk = 1'b0;
    logic        sreset;
    logic [2:0]  req_valid;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic        rr_enable;
    logic [15:0] min_interval;
    logic        err_clear;
    logic [15:0] dac_data;
    logic        dac_start;
    wire         dac_busy;
    logic [1:0]  grant_id;
    logic        timeout_err;
    logic [31:0] update_count;

    logic model_en = 1'b0, force_busy = 1'b0, model_busy = 1'b0;
    int   model_delay = 1, model_len = 5, m_wait = 0, m_run = 0;
    int   tests = 0, fails = 0, cyc_no = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    assign dac_busy = model_en ? model_busy : force_busy;

    // Serializer model: busy rises model_delay cycles after dac_start, stays up model_len cycles.
    always @(negedge clk) begin
        if (!model_en) begin
            model_busy = 1'b0;
            m_wait = 0;
            m_run = 0;
        end else if (dac_start) begin
            m_wait = model_delay;
            m_run = model_len;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) model_busy = 1'b1;
        end else if (m_run > 0) begin
            m_run--;
            if (m_run == 0) model_busy = 1'b0;
        end
    end

    dac_write_arbiter #(.DAC_WIDTH(16), .N_REQ(3), .BUSY_TIMEOUT(64)) dut (
        .clk(clk), .sreset(sreset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rr_enable(rr_enable), .min_interval(min_interval),
        .err_clear(err_clear), .dac_data(dac_data), .dac_start(dac_start), .dac_busy(dac_busy),
        .grant_id(grant_id), .timeout_err(timeout_err), .update_count(update_count)
    );

    task automatic do_reset();
        sreset = 1'b1; req_valid = '0; err_clear = 1'b0; model_en = 1'b0; force_busy = 1'b0;
        rr_enable = 1'b0; min_interval = 16'd0;
        req_data = {16'hC002, 16'hB001, 16'hA000};
        @(negedge clk); @(negedge clk);
        sreset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL reset_req_ready: got %b want 000", req_ready); end
        tests++; if (dac_start !== 1'b0) begin fails++; $display("FAIL reset_dac_start: got %b want 0", dac_start); end
        tests++; if (dac_data !== 16'h0) begin fails++; $display("FAIL reset_dac_data: got %h want 0000", dac_data); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        tests++; if (update_count !== 32'd0) begin fails++; $display("FAIL reset_update_count: got %0d want 0", update_count); end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        model_en = 1'b1; model_delay = 2; model_len = 20;
        req_data = {16'hC002, 16'hB001, 16'h1234};
        req_valid = 3'b001;
        #1;
        tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL single_ready: got %b want 001", req_ready); end
        tests++; if (dac_start !== 1'b0) begin fails++; $display("FAIL single_start_early: got %b want 0", dac_start); end
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        tests++; if (dac_start !== 1'b1) begin fails++; $display("FAIL single_start: got %b want 1", dac_start); end
        tests++; if (dac_data !== 16'h1234) begin fails++; $display("FAIL single_data: got %h want 1234", dac_data); end
        tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL single_ready_drop: got %b want 000", req_ready); end
        n = 0;
        while (update_count != 32'd1 && n < 60) begin @(negedge clk); n++; end
        tests++; if (update_count !== 32'd1) begin fails++; $display("FAIL single_count: got %0d want 1", update_count); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL single_grant: got %0d want 0", grant_id); end
    endtask

    task automatic test_arbitration(input logic rr, input logic [7:0] exp);
        int got, multi, n;
        logic [1:0] g[4];
        do_reset();
        model_en = 1'b1; model_delay = 1; model_len = 5;
        rr_enable = rr;
        req_valid = 3'b111;
        got = 0; multi = 0; n = 0;
        while (got < 4 && n < 200) begin
            #1;
            if (req_ready != 3'b000) begin
                if (!$onehot(req_ready)) multi++;
                g[got] = req_ready[1] ? 2'd1 : (req_ready[2] ? 2'd2 : 2'd0);
                got++;
            end
            @(negedge clk);
            n++;
        end
        req_valid = 3'b000;
        tests++; if (got !== 4) begin fails++; $display("FAIL arb_rr%0b_count: got %0d want 4", rr, got); end
        for (int k = 0; k < got; k++) begin
            tests++;
            if (g[k] !== exp[2*k +: 2]) begin
                fails++; $display("FAIL arb_rr%0b_grant%0d: got %0d want %0d", rr, k, g[k], exp[2*k +: 2]);
            end
        end
        tests++; if (multi !== 0) begin fails++; $display("FAIL arb_rr%0b_onehot: got %0d bad want 0", rr, multi); end
        n = 0;
        while (update_count != 32'd4 && n < 60) begin @(negedge clk); n++; end
        tests++; if (update_count !== 32'd4) begin fails++; $display("FAIL arb_rr%0b_updates: got %0d want 4", rr, update_count); end
    endtask

    task automatic test_min_interval();
        int st[8], rd[8];
        int ns, nr, bad;
        do_reset();
        model_en = 1'b1; model_delay = 1; model_len = 10;
        min_interval = 16'd100;
        req_valid = 3'b010;
        ns = 0; nr = 0; bad = 0;
        for (int c = 0; c < 330; c++) begin
            #1;
            if (dac_start) begin if (ns < 8) st[ns] = cyc_no; ns++; end
            if (req_ready != 3'b000) begin
                if (req_ready !== 3'b010) bad++;
                if (nr < 8) rd[nr] = cyc_no;
                nr++;
            end
            @(negedge clk);
        end
        req_valid = 3'b000;
        tests++; if (ns !== 4) begin fails++; $display("FAIL interval_starts: got %0d want 4", ns); end
        tests++; if (nr !== 4) begin fails++; $display("FAIL interval_accepts: got %0d want 4", nr); end
        for (int k = 1; k < 4 && k < ns; k++) begin
            tests++;
            if (st[k] - st[k-1] !== 100) begin
                fails++; $display("FAIL interval_gap%0d: got %0d want 100", k, st[k] - st[k-1]);
            end
        end
        for (int k = 0; k < 4 && k < nr && k < ns; k++) if (rd[k] != st[k] - 1) bad++;
        tests++; if (bad !== 0) begin fails++; $display("FAIL interval_ready_timing: got %0d bad want 0", bad); end
        min_interval = 16'd0;
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        req_valid = 3'b001;
        @(negedge clk);
        req_valid = 3'b000;
        tests++; if (dac_start !== 1'b1) begin fails++; $display("FAIL timeout_start: got %b want 1", dac_start); end
        n = 0;
        while (!timeout_err && n < 100) begin @(negedge clk); n++; end
        // 64 cycles in WAIT_BUSY, flag visible on the cycle after
        tests++; if (n !== 65) begin fails++; $display("FAIL timeout_latency: got %0d want 65", n); end
        tests++; if (update_count !== 32'd0) begin fails++; $display("FAIL timeout_count: got %0d want 0", update_count); end
        req_valid = 3'b001;
        #1;
        tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL timeout_idle: got %b want 001", req_ready); end
        req_valid = 3'b000;
        @(negedge clk);
        tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_clear: got %b want 0", timeout_err); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        model_en = 1'b1; model_delay = 1; model_len = 20;
        req_valid = 3'b001;
        @(negedge clk);
        req_valid = 3'b000;
        repeat (5) @(negedge clk);
        sreset = 1'b1;
        req_valid = 3'b100;
        #1;
        tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL rstmid_ready_in_reset: got %b want 000", req_ready); end
        @(negedge clk);
        sreset = 1'b0;
        tests++; if (dac_start !== 1'b0) begin fails++; $display("FAIL rstmid_start: got %b want 0", dac_start); end
        tests++; if (dac_data !== 16'h0) begin fails++; $display("FAIL rstmid_data: got %h want 0000", dac_data); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL rstmid_grant: got %0d want 0", grant_id); end
        tests++; if (update_count !== 32'd0) begin fails++; $display("FAIL rstmid_count: got %0d want 0", update_count); end
        #1;
        tests++; if (req_ready !== 3'b100) begin fails++; $display("FAIL rstmid_first_accept: got %b want 100", req_ready); end
        @(negedge clk);
        req_valid = 3'b000;
        tests++; if (grant_id !== 2'd2) begin fails++; $display("FAIL rstmid_grant2: got %0d want 2", grant_id); end
        tests++; if (dac_data !== 16'hC002) begin fails++; $display("FAIL rstmid_data2: got %h want c002", dac_data); end
        n = 0;
        while (update_count != 32'd1 && n < 60) begin @(negedge clk); n++; end
        tests++; if (update_count !== 32'd1) begin fails++; $display("FAIL rstmid_done: got %0d want 1", update_count); end
    endtask

    task automatic test_handoff();
        int n, early, hold_bad;
        do_reset();
        model_en = 1'b1; model_delay = 1; model_len = 5;
        req_valid = 3'b100;
        #1;
        tests++; if (req_ready !== 3'b100) begin fails++; $display("FAIL handoff_accept2: got %b want 100", req_ready); end
        @(negedge clk);
        req_valid = 3'b000;
        @(negedge clk);
        @(negedge clk);
        req_valid = 3'b001;
        n = 0; early = 0; hold_bad = 0;
        while (update_count == 32'd0 && n < 40) begin
            #1;
            if (req_ready != 3'b000) early++;
            if (dac_data !== 16'hC002) hold_bad++;
            @(negedge clk);
            n++;
        end
        tests++; if (early !== 0) begin fails++; $display("FAIL handoff_early_ready: got %0d want 0", early); end
        tests++; if (hold_bad !== 0) begin fails++; $display("FAIL handoff_data_hold: got %0d bad want 0", hold_bad); end
        #1;
        tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL handoff_accept0: got %b want 001", req_ready); end
        tests++; if (dac_data !== 16'hC002) begin fails++; $display("FAIL handoff_data_pre: got %h want c002", dac_data); end
        @(negedge clk);
        req_valid = 3'b000;
        tests++; if (dac_data !== 16'hA000) begin fails++; $display("FAIL handoff_data_new: got %h want a000", dac_data); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL handoff_grant: got %0d want 0", grant_id); end
        n = 0;
        while (update_count != 32'd2 && n < 60) begin @(negedge clk); n++; end
        tests++; if (update_count !== 32'd2) begin fails++; $display("FAIL handoff_done: got %0d want 2", update_count); end
    endtask

    initial begin
        sreset = 1'b1; req_valid = '0; req_data = '0; rr_enable = 1'b0;
        min_interval = 16'd0; err_clear = 1'b0;
        test_reset();
        test_single();
        test_arbitration(1'b0, {2'd0, 2'd0, 2'd0, 2'd0});
        test_arbitration(1'b1, {2'd0, 2'd2, 2'd1, 2'd0});
        test_min_interval();
        test_timeout();
        test_reset_mid();
        test_handoff();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failed so far", fails);
        $fatal(1);
    end

endmodule

// File: doc/dac_write_arbiter.md
Name: dac_write_arbiter

Overview:
- Shares the single DAC8411 serial write engine among several update sources, for example the loop-filter output, a bus-written manual setpoint and a sweep generator.
- Arbitrates valid/ready requests using either fixed priority or round-robin.
- Enforces a programmable minimum interval between DAC updates.
- Issues a start pulse and tracks the serializer busy handshake, with a timeout guard.
- Sits between the PLL datapath sources and the DAC serializer, in the same clock domain as the ADC/DAC drivers.

Parameters:
- DAC_WIDTH, 16, width of each DAC code.
- N_REQ, 3, number of requesters (2..8).
- BUSY_TIMEOUT, 64, cycles allowed after dac_start for dac_busy to rise.

Ports:
- clk  in  1  IP clock, shared with the ADC/DAC drivers.
- sreset  in  1  synchronous reset, active high.
- req_valid  in  N_REQ  per-requester request.
- req_data  in  N_REQ*DAC_WIDTH  flattened codes; requester i uses bits [i*DAC_WIDTH +: DAC_WIDTH].
- req_ready  out  N_REQ  one-hot accept pulse.
- rr_enable  in  1  0 = fixed priority (index 0 highest); 1 = round-robin.
- min_interval  in  16  minimum clk cycles between consecutive dac_start pulses.
- err_clear  in  1  clears timeout_err.
- dac_data  out  DAC_WIDTH  code presented to the serializer.
- dac_start  out  1  one-cycle start pulse to the serializer.
- dac_busy  in  1  serializer busy.
- grant_id  out  $clog2(N_REQ)  index of the last accepted requester.
- timeout_err  out  1  sticky busy-timeout flag.
- update_count  out  32  completed DAC updates; wraps.

Behaviour:
- Reset state:
  - req_ready = 0, dac_start = 0, dac_data = 0, grant_id = 0, timeout_err = 0, update_count = 0.
  - FSM = IDLE.
  - Round-robin pointer = N_REQ-1, so the first round-robin grant goes to index 0.
  - since_start saturated at 16'hFFFF, so the first accept is never interval-blocked.
- Reset mid-operation: abandons any transfer immediately. No dac_start is issued afterwards, and update_count is not incremented.
- since_start counter:
  - Cleared to 0 in the dac_start cycle.
  - Otherwise increments each cycle, saturating at 16'hFFFF.
  - The interval is met when since_start+1 >= min_interval. min_interval of 0 or 1 imposes no limit beyond the FSM.
- IDLE:
  - Accepts a request when any req_valid is high and the interval is met.
  - Fixed priority: the lowest asserted index wins.
  - Round-robin: search starts at pointer+1 (mod N_REQ); the first asserted index wins; pointer := winner.
  - In the accept cycle: req_ready[winner] = 1 for exactly one cycle. dac_data <= req_data[winner] and grant_id <= winner, both registered at the clock edge. Next state START.
  - Otherwise stays in IDLE with req_ready = 0.
- START: dac_start = 1 for exactly this cycle, since_start := 0, timeout counter := 0. Next state WAIT_BUSY.
  - Latency: the accept cycle is t, dac_start is at t+1, and dac_data is valid from t+1 and held until the next accept.
- WAIT_BUSY:
  - dac_busy = 1 → WAIT_DONE.
  - Else if the timeout counter reaches BUSY_TIMEOUT-1 → timeout_err := 1 and go to IDLE; update_count is unchanged.
  - Else increment the timeout counter.
- WAIT_DONE: on dac_busy = 0 → update_count += 1 (wraps at 2^32) and go to IDLE. There is no timeout in this state.
- Handshake rules:
  - A requester must hold req_valid and req_data until it sees req_ready.
  - A requester may drop req_valid after acceptance.
  - The arbiter never asserts more than one req_ready bit in a cycle.
  - req_ready is never asserted outside IDLE.
- rr_enable and min_interval are sampled in every IDLE cycle; a change takes effect at the next arbitration. The round-robin pointer is still updated while in fixed-priority mode.
- timeout_err:
  - Set has priority over err_clear in the same cycle.
  - err_clear in any other cycle clears it.
- Simultaneous events: a request arriving while not in IDLE waits; there is no queueing inside the arbiter.

Test Plan:
1. Reset, then req_valid = 3'b001 with data 16'h1234, min_interval = 0, dac_busy high for 20 cycles starting 2 cycles after start → req_ready[0] at t, dac_start at t+1, dac_data = 16'h1234, update_count = 1, grant_id = 0.
2. rr_enable = 0, req_valid = 3'b111 held continuously, dac_busy driven by a model with 5-cycle busy, 4 updates → grants 0,0,0,0. Repeat with rr_enable = 1 → grants 0,1,2,0.
3. min_interval = 100, requester 1 always valid, busy 10 cycles → consecutive dac_start pulses exactly 100 cycles apart; req_ready never asserted earlier.
4. dac_busy tied low, one request → timeout_err rises at cycle t+1+BUSY_TIMEOUT (±1 per definition, check exactly 64 cycles in WAIT_BUSY), FSM returns to IDLE, update_count = 0. err_clear pulse → timeout_err = 0.
5. Assert sreset in WAIT_DONE with dac_busy high → next cycle all outputs at reset values. With req_valid = 3'b100 held → first accept goes to 2 immediately, with no interval block.
6. Requester 2 drops req_valid the cycle after req_ready while requester 0 rises in WAIT_DONE → requester 0 is accepted on the first IDLE cycle; dac_data keeps requester 2's code until that accept.
